// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the iterative divider
// Contents:
//   OP_DIV/OP_DIVU/OP_REM/OP_REMU : 2-bit operation encodings
//   state_t                       : divider FSM states
//   DIV_ZERO_Q                    : quotient returned on divide-by-zero
package div_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
// Ports:
//   rem      in  XLEN  partial remainder before this step
//   q_msb    in  1     dividend bit shifted into the remainder this step
//   divisor  in  XLEN  unsigned divisor magnitude
//   next_rem out XLEN  partial remainder after this step
//   q_bit    out 1     quotient bit produced by this step
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic            q_msb,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] next_rem,
   output logic            q_bit
);

   logic [XLEN:0] w_shifted;
   logic [XLEN:0] w_trial;

   // The remainder is always below the divisor, so the XLEN+1 bit
   // difference fits and its top bit is a clean "went negative" flag.
   assign w_shifted = {rem, q_msb};
   assign w_trial   = w_shifted - {1'b0, divisor};
   assign q_bit     = ~w_trial[XLEN];
   assign next_rem  = q_bit ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider (DIV/DIVU/REM/REMU)
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operation request / accept (ready only in IDLE)
//   op, a, b             operation, dividend, divisor (sampled on accept)
//   flush                abandon the in-flight operation
//   out_valid/out_ready  result handshake
//   result               quotient or remainder
//   busy                 high while computing or holding a result
module div_iter
   import div_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_q;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_divisor;
   logic [XLEN-1:0] r_result;
   logic [CNT_W-1:0] r_cnt;
   logic            r_is_rem;
   logic            r_neg_q;
   logic            r_neg_r;

   logic            w_accept;
   logic            w_step;
   logic            w_signed;
   logic            w_is_rem;
   logic            w_special;
   logic [XLEN-1:0] w_special_result;
   logic [XLEN-1:0] w_a_abs;
   logic [XLEN-1:0] w_b_abs;
   logic [XLEN-1:0] w_next_rem;
   logic            w_q_bit;
   logic [XLEN-1:0] w_q_final;
   logic [XLEN-1:0] w_q_fixed;
   logic [XLEN-1:0] w_r_fixed;

   // Operand decode at accept time
   assign w_signed = (op == OP_DIV) || (op == OP_REM);
   assign w_is_rem = (op == OP_REM) || (op == OP_REMU);
   assign w_a_abs  = (w_signed && a[XLEN-1]) ? -a : a;
   assign w_b_abs  = (w_signed && b[XLEN-1]) ? -b : b;

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   always_comb begin
      w_special        = 1'b0;
      w_special_result = '0;
      if (b == '0) begin
         w_special        = 1'b1;
         w_special_result = w_is_rem ? a : DIV_ZERO_Q;
      end else if (w_signed && (a == MIN_NEG) && (b == ALL_ONES)) begin
         w_special        = 1'b1;
         w_special_result = w_is_rem ? '0 : MIN_NEG;
      end
   end

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (r_rem),
      .q_msb    (r_q[XLEN-1]),
      .divisor  (r_divisor),
      .next_rem (w_next_rem),
      .q_bit    (w_q_bit)
   );

   // Final step's values are fixed up and registered in the same cycle.
   assign w_q_final = {r_q[XLEN-2:0], w_q_bit};
   assign w_q_fixed = r_neg_q ? -w_q_final : w_q_final;
   assign w_r_fixed = r_neg_r ? -w_next_rem : w_next_rem;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && !flush) begin
               w_accept     = 1'b1;
               w_state_next = w_special ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (flush) begin
               w_state_next = S_IDLE;
            end else begin
               w_step = 1'b1;
               if (r_cnt == '0) w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (flush || out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q       <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_is_rem  <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
      end else if (w_accept) begin
         r_is_rem  <= w_is_rem;
         r_neg_q   <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
         r_neg_r   <= w_signed && a[XLEN-1];
         r_q       <= w_a_abs;
         r_divisor <= w_b_abs;
         r_rem     <= '0;
         r_cnt     <= CNT_W'(XLEN - 1);
         if (w_special) r_result <= w_special_result;
      end else if (w_step) begin
         r_rem <= w_next_rem;
         r_q   <= w_q_final;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == '0) r_result <= r_is_rem ? w_r_fixed : w_q_fixed;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
   assign result    = r_result;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - scoreboard testbench for div_iter
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   bit          stall_en = 1'b0;

   div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic ovf;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      case (o)
         2'b01:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         2'b11:   return (y == 0) ? x : x % y;
         2'b00:   return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(x) / $signed(y));
         default: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      endcase
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 200) begin
         step();
         n++;
      end
      if (!in_ready) chk("idle_timeout", {31'b0, in_ready}, 32'h1);
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] e, input int exp_lat);
      int lat;
      wait_idle();
      op       = o;
      a        = da;
      b        = db;
      in_valid = 1'b1;
      exp_q.push_back(e);
      step();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
   endtask

   // Monitor: a transfer happens on the next rising edge whenever these hold.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", result, 32'hDEAD_BEEF);
            end else begin
               e = exp_q.pop_front();
               chk("result", result, e);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        seen;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 2'b00;
      a         = '0;
      b         = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_busy",      {31'b0, busy},      32'h0);
      chk("rst_result",    result,             32'h0);
      rst = 1'b0;
      step();

      // Directed arithmetic
      do_op(2'b01, 32'd100,        32'd7,          32'd14,         33);
      do_op(2'b11, 32'd100,        32'd7,          32'd2,          33);
      do_op(2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
      do_op(2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
      do_op(2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
      do_op(2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
      do_op(2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
      do_op(2'b10, 32'd5,          32'd0,          32'd5,          1);
      do_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
      do_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1);

      // Backpressure: result held, new requests ignored
      wait_idle();
      out_ready = 1'b0;
      do_op(2'b01, 32'd100, 32'd7, 32'd14, 33);
      for (int i = 0; i < 5; i++) begin
         op       = 2'b01;
         a        = 32'd1;
         b        = 32'd1;
         in_valid = 1'b1;
         step();
         chk("bp_result",   result,             32'd14);
         chk("bp_in_ready", {31'b0, in_ready},  32'h0);
         chk("bp_valid",    {31'b0, out_valid}, 32'h1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_release_ready", {31'b0, in_ready},  32'h1);
      chk("bp_release_valid", {31'b0, out_valid}, 32'h0);
      do_op(2'b01, 32'd1000, 32'd10, 32'd100, 33);

      // Flush in IDLE blocks acceptance
      wait_idle();
      step();
      op       = 2'b01;
      a        = 32'd9;
      b        = 32'd3;
      in_valid = 1'b1;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("idle_flush_busy", {31'b0, busy}, 32'h0);

      // Flush mid-CALC: no result, previous result kept
      do_op(2'b11, 32'd100, 32'd7, 32'd2, 33);
      wait_idle();
      op       = 2'b01;
      a        = 32'h0000_FFFF;
      b        = 32'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_in_ready",  {31'b0, in_ready},  32'h1);
      chk("flush_busy",      {31'b0, busy},      32'h0);
      chk("flush_result",    result,             32'd2);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("flush_no_valid", {31'b0, seen}, 32'h0);

      // Reset mid-CALC
      op       = 2'b01;
      a        = 32'd12345;
      b        = 32'd11;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      chk("mrst_in_ready",  {31'b0, in_ready},  32'h1);
      chk("mrst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("mrst_busy",      {31'b0, busy},      32'h0);
      chk("mrst_result",    result,             32'h0);
      rst = 1'b0;
      step();
      do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

      // Random operands with random output stalls
      stall_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: rb = -32'($urandom_range(1, 15));
            default: ;
         endcase
         do_op(ro, ra, rb, ref_div(ro, ra, rb),
               ((rb == 0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33);
      end
      stall_en  = 1'b0;
      step();
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      chk("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
